// File: rtl/lsu_stage_if.sv
// Load/store stage bus bundle: request from execute, response to writeback,
// and the data port of the simulation RAM.
interface lsu_stage_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [4:0]  req_rd;

  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        resp_misalign;

  logic        mem_read;
  logic        mem_write;
  logic [63:0] write_mask;
  logic [63:0] data_addr;
  logic [63:0] write_data;
  logic [63:0] read_data;

  // Stage side
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    output req_ready,
    output resp_valid, resp_rdata, resp_rd, resp_misalign,
    input  resp_ready,
    output mem_read, mem_write, write_mask, data_addr, write_data,
    input  read_data
  );

  // Environment side (execute, writeback and RAM)
  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, req_rd,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_rd, resp_misalign,
    output resp_ready,
    input  mem_read, mem_write, write_mask, data_addr, write_data,
    output read_data
  );
endinterface

// File: rtl/lsu_stage.sv
// Load/store access stage: latches one request, drives the RAM data port for
// a single ACCESS cycle, then holds the extended result until writeback takes it.
module lsu_stage #(
  parameter bit MISALIGN_TRAP = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  lsu_stage_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state_q, state_d;

  logic        r_we, r_uns;
  logic [1:0]  r_size;
  logic [63:0] r_addr, r_wdata;
  logic [4:0]  r_rd;

  logic [63:0] rdata_q;
  logic [4:0]  rd_q;
  logic        mis_q;

  logic        ready_c, accept, in_access;
  logic [2:0]  off, align_mask;
  logic        misaligned, mis_gate;
  logic [3:0]  nbytes, lane_lo, lane_hi;
  logic [7:0]  bm;
  logic [63:0] mask_full, shifted, load_ext;

  assign ready_c   = (state_q == IDLE) | ((state_q == RESP) & bus.resp_ready);
  assign accept    = bus.req_valid & ready_c;
  assign in_access = (state_q == ACCESS);

  // Next-state: ACCESS is always one cycle; RESP may chain straight into ACCESS
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = ACCESS;
      ACCESS:  state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = accept ? ACCESS : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Request register: memory outputs decode only from here, never from req_*
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_size  <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
    end else if (accept) begin
      r_we    <= bus.req_we;
      r_uns   <= bus.req_unsigned;
      r_size  <= bus.req_size;
      r_addr  <= bus.req_addr;
      r_wdata <= bus.req_wdata;
      r_rd    <= bus.req_rd;
    end
  end

  // Size decode, alignment, byte lanes and load extraction
  always_comb begin
    off        = r_addr[2:0];
    align_mask = '0;
    nbytes     = 4'd1;
    case (r_size)
      2'd0: begin align_mask = 3'b000; nbytes = 4'd1; end
      2'd1: begin align_mask = 3'b001; nbytes = 4'd2; end
      2'd2: begin align_mask = 3'b011; nbytes = 4'd4; end
      2'd3: begin align_mask = 3'b111; nbytes = 4'd8; end
    endcase
    misaligned = |(off & align_mask);
    mis_gate   = misaligned & MISALIGN_TRAP;

    // Lanes past byte 7 simply fall off the word (truncation at the boundary)
    lane_lo   = {1'b0, off};
    lane_hi   = lane_lo + nbytes;
    bm        = '0;
    mask_full = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      bm[i]            = (4'(i) >= lane_lo) && (4'(i) < lane_hi);
      mask_full[i*8+:8] = {8{bm[i]}};
    end

    shifted  = bus.read_data >> {off, 3'b000};
    load_ext = shifted;
    case (r_size)
      2'd0: load_ext = r_uns ? {56'd0, shifted[7:0]}  : {{56{shifted[7]}},  shifted[7:0]};
      2'd1: load_ext = r_uns ? {48'd0, shifted[15:0]} : {{48{shifted[15]}}, shifted[15:0]};
      2'd2: load_ext = r_uns ? {32'd0, shifted[31:0]} : {{32{shifted[31]}}, shifted[31:0]};
      2'd3: load_ext = shifted;
    endcase
  end

  // Response capture at the end of ACCESS; held until the next ACCESS
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rd_q    <= '0;
      mis_q   <= 1'b0;
    end else if (in_access) begin
      rdata_q <= (r_we | mis_gate) ? '0 : load_ext;
      rd_q    <= r_rd;
      mis_q   <= misaligned;
    end
  end

  assign bus.req_ready     = ready_c;
  assign bus.resp_valid    = (state_q == RESP);
  assign bus.resp_rdata    = rdata_q;
  assign bus.resp_rd       = rd_q;
  assign bus.resp_misalign = mis_q;

  assign bus.mem_read   = in_access & ~r_we & ~mis_gate;
  assign bus.mem_write  = in_access &  r_we & ~mis_gate;
  assign bus.write_mask = in_access ? mask_full : '0;
  assign bus.data_addr  = {r_addr[63:3], 3'b000};
  assign bus.write_data = r_wdata << {off, 3'b000};

endmodule

// File: tb/tb_lsu_stage.sv
// Bench for lsu_stage: directed scenarios plus random traffic, checked against
// a byte-addressed reference memory and per-byte lane arithmetic.
module tb_lsu_stage;

  localparam bit TRAP = 1'b1;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [4:0]  rd;
  } txn_t;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  lsu_stage_if bus ();

  lsu_stage #(.MISALIGN_TRAP(TRAP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Simulation RAM: 16 dwords, combinational read, masked write on the edge
  logic [63:0] ram [16] = '{default: 64'h0};
  assign bus.read_data = ram[bus.data_addr[6:3]];
  always @(posedge clk)
    if (bus.mem_write)
      ram[bus.data_addr[6:3]] <= (ram[bus.data_addr[6:3]] & ~bus.write_mask) |
                                 (bus.write_data & bus.write_mask);

  // Reference memory, one entry per byte
  logic [7:0] ref_mem [128] = '{default: 8'h0};

  function automatic int nb_of(input logic [1:0] size);
    return 1 << size;
  endfunction

  function automatic bit is_mis(input txn_t t);
    return (int'(t.addr[2:0]) % nb_of(t.size)) != 0;
  endfunction

  function automatic logic [63:0] exp_mask(input txn_t t);
    logic [63:0] m = '0;
    for (int i = 0; i < nb_of(t.size); i++)
      if (int'(t.addr[2:0]) + i < 8) m[(int'(t.addr[2:0]) + i)*8 +: 8] = 8'hFF;
    return m;
  endfunction

  function automatic logic [63:0] exp_wdata(input txn_t t);
    logic [63:0] d = '0;
    for (int i = 0; i < nb_of(t.size); i++)
      if (int'(t.addr[2:0]) + i < 8) d[(int'(t.addr[2:0]) + i)*8 +: 8] = t.wdata[i*8 +: 8];
    return d;
  endfunction

  function automatic logic [63:0] model_word(input int idx);
    logic [63:0] w;
    for (int b = 0; b < 8; b++) w[b*8 +: 8] = ref_mem[idx*8 + b];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input txn_t t);
    logic [63:0] v = '0;
    int nb = nb_of(t.size);
    int base = int'(t.addr[6:3]) * 8;
    if (t.we || (is_mis(t) && TRAP)) return 64'h0;
    for (int i = 0; i < nb; i++)
      if (int'(t.addr[2:0]) + i < 8) v[i*8 +: 8] = ref_mem[base + int'(t.addr[2:0]) + i];
    if (nb < 8 && !t.uns && v[nb*8-1])
      for (int b = nb*8; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic model_commit(input txn_t t);
    int base = int'(t.addr[6:3]) * 8;
    if (!t.we || (is_mis(t) && TRAP)) return;
    for (int i = 0; i < nb_of(t.size); i++)
      if (int'(t.addr[2:0]) + i < 8) ref_mem[base + int'(t.addr[2:0]) + i] = t.wdata[i*8 +: 8];
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [63:0] addr, input logic [63:0] wdata,
                              input logic [4:0] rd);
    txn_t t;
    t.we = we; t.size = size; t.uns = uns; t.addr = addr; t.wdata = wdata; t.rd = rd;
    return t;
  endfunction

  task automatic put_req(input txn_t t);
    bus.req_valid    = 1'b1;
    bus.req_we       = t.we;
    bus.req_size     = t.size;
    bus.req_unsigned = t.uns;
    bus.req_addr     = t.addr;
    bus.req_wdata    = t.wdata;
    bus.req_rd       = t.rd;
  endtask

  task automatic chk_access(input txn_t t);
    bit mis = is_mis(t) && TRAP;
    chk("acc_state_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("acc_req_ready", 64'(bus.req_ready), 64'd0);
    chk("acc_mem_read", 64'(bus.mem_read), 64'(!t.we && !mis));
    chk("acc_mem_write", 64'(bus.mem_write), 64'(t.we && !mis));
    chk("acc_data_addr", bus.data_addr, {t.addr[63:3], 3'b000});
    chk("acc_write_mask", bus.write_mask, exp_mask(t));
    if (t.we) chk("acc_write_data", bus.write_data & exp_mask(t), exp_wdata(t));
  endtask

  task automatic chk_resp(input txn_t t, input logic [63:0] exp_rdata);
    chk("resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("resp_rd", 64'(bus.resp_rd), 64'(t.rd));
    chk("resp_misalign", 64'(bus.resp_misalign), 64'(is_mis(t)));
    chk("resp_rdata", bus.resp_rdata, exp_rdata);
    chk("resp_mem_idle", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    chk("resp_mask_idle", bus.write_mask, 64'd0);
  endtask

  // Full transaction from IDLE back to IDLE; returns the observed response data
  task automatic single(input txn_t t, output logic [63:0] got);
    logic [63:0] exp;
    put_req(t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_access(t);
    exp = model_load(t);
    model_commit(t);
    @(posedge clk); #1;
    chk_resp(t, exp);
    got = bus.resp_rdata;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("idle_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  localparam logic [63:0] BASE = 64'h0000_0000_8000_0000;

  initial begin
    txn_t t, t2;
    logic [63:0] got, exp, hold_rdata;
    logic [4:0]  hold_rd;
    logic        hold_mis;
    int          start_cyc, nresp;

    rst_n = 1'b0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = '0; bus.req_unsigned = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0; bus.req_rd = '0; bus.resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_resp_rd", 64'(bus.resp_rd), 64'd0);
    chk("rst_resp_misalign", 64'(bus.resp_misalign), 64'd0);
    chk("rst_mem_en", 64'({bus.mem_read, bus.mem_write}), 64'd0);
    chk("rst_write_mask", bus.write_mask, 64'd0);
    chk("rst_data_addr", bus.data_addr, 64'd0);
    chk("rst_write_data", bus.write_data, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Fill RAM with random dwords through the stage
    for (int i = 0; i < 16; i++)
      single(mk(1'b1, 2'd3, 1'b0, BASE + 64'(i*8), {$urandom, $urandom}, 5'(i)), got);

    // Byte store at 0x8000_0005
    t = mk(1'b1, 2'd0, 1'b0, BASE + 64'd5, 64'h0000_0000_0000_00AB, 5'd3);
    put_req(t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_access(t);
    chk("byte_mask_const", bus.write_mask, 64'h0000_FF00_0000_0000);
    chk("byte_addr_const", bus.data_addr, BASE);
    got = bus.write_data;
    chk("byte_data_lane", 64'(got[47:40]), 64'hAB);
    model_commit(t);
    @(posedge clk); #1;
    chk_resp(t, 64'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;

    // Load extension from 0x80FF_0000_0000_0000
    single(mk(1'b1, 2'd3, 1'b0, BASE, 64'h80FF_0000_0000_0000, 5'd1), got);
    single(mk(1'b0, 2'd1, 1'b0, BASE + 64'd6, 64'd0, 5'd4), got);
    chk("ldh_signed_const", got, 64'hFFFF_FFFF_FFFF_80FF);
    single(mk(1'b0, 2'd1, 1'b1, BASE + 64'd6, 64'd0, 5'd5), got);
    chk("ldh_unsigned_const", got, 64'h0000_0000_0000_80FF);

    // Misaligned word load is suppressed but still answered
    single(mk(1'b0, 2'd2, 1'b0, BASE + 64'd2, 64'd0, 5'd7), got);
    chk("mis_rdata_const", got, 64'd0);

    // Back-pressure for 5 cycles, then consume and accept at the same edge
    t  = mk(1'b0, 2'd2, 1'b0, BASE + 64'h14, 64'd0, 5'd9);
    t2 = mk(1'b1, 2'd1, 1'b0, BASE + 64'h22, 64'h0000_0000_0000_BEEF, 5'd10);
    put_req(t);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk_access(t);
    exp = model_load(t);
    @(posedge clk); #1;
    chk_resp(t, exp);
    hold_rdata = bus.resp_rdata; hold_rd = bus.resp_rd; hold_mis = bus.resp_misalign;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("bp_req_ready", 64'(bus.req_ready), 64'd0);
      chk("bp_mem_en", 64'({bus.mem_read, bus.mem_write}), 64'd0);
      chk("bp_stable", {bus.resp_rdata ^ exp, 59'(0)} == '0 ? 64'(bus.resp_rd) : 64'hDEAD, 64'(t.rd));
    end
    put_req(t2);
    bus.resp_ready = 1'b1;
    #1;
    chk("bp_release_req_ready", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.resp_ready = 1'b0;
    chk_access(t2);
    model_commit(t2);
    @(posedge clk); #1;
    chk_resp(t2, 64'd0);
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    if (hold_rd != t.rd || hold_mis != is_mis(t) || hold_rdata != exp) begin
      checks++; errors++;
      $error("FAIL bp_capture: observed %h expected %h", hold_rdata, exp);
    end

    // Reset during the ACCESS cycle of a store
    t = mk(1'b1, 2'd3, 1'b0, BASE + 64'h40, 64'h1122_3344_5566_7788, 5'd12);
    single(t, got);
    t2 = mk(1'b1, 2'd3, 1'b0, BASE + 64'h40, 64'hDEAD_BEEF_CAFE_F00D, 5'd13);
    put_req(t2);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("rst_acc_write_pre", 64'(bus.mem_write), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_acc_mem_write", 64'(bus.mem_write), 64'd0);
    chk("rst_acc_req_ready", 64'(bus.req_ready), 64'd1);
    chk("rst_acc_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_acc_resp_rdata", bus.resp_rdata, 64'd0);
    chk("rst_acc_resp_rd", 64'(bus.resp_rd), 64'd0);
    chk("rst_acc_mask", bus.write_mask, 64'd0);
    chk("rst_acc_data_addr", bus.data_addr, 64'd0);
    chk("rst_acc_write_data", bus.write_data, 64'd0);
    @(posedge clk); #1;
    chk("rst_acc_ram_kept", ram[8], model_word(8));
    rst_n = 1'b1;
    @(posedge clk); #1;
    single(mk(1'b0, 2'd3, 1'b0, BASE + 64'h40, 64'd0, 5'd14), got);
    chk("rst_acc_reload", got, 64'h1122_3344_5566_7788);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      t = mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
             BASE + 64'($urandom_range(0, 127)), {$urandom, $urandom}, 5'($urandom_range(0, 31)));
      single(t, got);
    end

    // Streaming: 8 dword loads, resp_ready held high
    nresp = 0;
    start_cyc = 0;
    bus.resp_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      t = mk(1'b0, 2'd3, 1'b0, BASE + 64'(k*8), 64'd0, 5'(k + 20));
      put_req(t);
      @(posedge clk); #1;
      if (k == 0) start_cyc = cyc;
      if (k == 7) bus.req_valid = 1'b0;
      chk_access(t);
      @(posedge clk); #1;
      chk_resp(t, model_load(t));
      chk("stream_req_ready", 64'(bus.req_ready), 64'd1);
      if (bus.resp_valid) nresp++;
    end
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
    chk("stream_cycles", 64'(cyc - start_cyc), 64'd16);
    chk("stream_count", 64'(nresp), 64'd8);
    chk("stream_idle", 64'(bus.resp_valid), 64'd0);

    // Final RAM image against the reference memory
    for (int i = 0; i < 16; i++) chk("ram_image", ram[i], model_word(i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
